alu_seq: RTL and testbench

Parametrised, handshaked successor to the single-cycle combinational ALU. It keeps the existing 4-bit opcode encoding and adds three things:
- registered outputs with a valid/ready handshake on both sides;
- a configurable datapath width;
- an optional iterative shift-add multiplier.

It sits between operand fetch and writeback. Multi-cycle operations stall the upstream stage through `in_ready`.

---
 rtl/alu_pkg.sv | 24 ++
 rtl/alu_mul_iter.sv | 56 +++++
 rtl/alu_seq.sv | 125 ++++++++++++
 tb/tb_alu_seq.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcode encodings and FSM state type.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package alu_pkg;

    // Opcode encoding carried over unchanged from the combinational ALU.
    localparam logic [3:0] ALUOP_AND = 4'b0000;
    localparam logic [3:0] ALUOP_OR  = 4'b0001;
    localparam logic [3:0] ALUOP_ADD = 4'b0010;
    localparam logic [3:0] ALUOP_MUL = 4'b0011;
    localparam logic [3:0] ALUOP_LT  = 4'b0100;
    localparam logic [3:0] ALUOP_XOR = 4'b0101;
    localparam logic [3:0] ALUOP_SUB = 4'b0110;
    localparam logic [3:0] ALUOP_SRL = 4'b1000;
    localparam logic [3:0] ALUOP_SLL = 4'b1001;
    localparam logic [3:0] ALUOP_SRA = 4'b1010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } alu_state_t;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: low WIDTH bits of an unsigned product.
// Latency: start at edge N, done asserted during the cycle before edge N+WIDTH.
// Backpressure: none; the caller must capture product while done is high.
// Ports: clk, resetn (async active-low), start (load operands), mcand_in/mplier_in
//        (operands), done (final iteration this cycle), product (valid with done).
module alu_mul_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [WIDTH-1:0] mcand_in,
    input  logic [WIDTH-1:0] mplier_in,
    output logic             done,
    output logic [WIDTH-1:0] product
);

    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc;
    logic [SHW-1:0]   count;
    logic             active;

    // Product includes the current iteration's partial term, so the final
    // step's sum can be taken directly without an extra settle cycle.
    assign product = acc + (mplier[0] ? mcand : '0);
    assign done    = active && (count == SHW'(WIDTH - 1));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            count  <= '0;
            active <= 1'b0;
        end else if (start) begin
            mcand  <= mcand_in;
            mplier <= mplier_in;
            acc    <= '0;
            count  <= '0;
            active <= 1'b1;
        end else if (active) begin
            acc    <= product;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count + 1'b1;
            if (done) begin
                active <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU with registered result/zero; optional iterative MUL (macro ALU_SEQ_MUL_EN).
// Latency: single-cycle ops valid after the accepting edge; MUL valid WIDTH edges after accept.
// Backpressure: in_ready drops while multiplying or while a result waits for out_ready.
// Ports: clk, resetn (async active-low); in_valid/in_ready with op1, op2, alu_op;
//        out_valid/out_ready with result, zero; busy flags a multiply in flight.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    input  logic [3:0]       alu_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             busy
);

    alu_state_t       state;
    logic             accept;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] comb_res;

    assign in_ready = (state == IDLE) || ((state == DONE) && out_ready);
    assign accept   = in_valid && in_ready;
    assign shamt    = op2[SHW-1:0];

    // Single-cycle datapath. MUL and unknown opcodes land in default (zero).
    always_comb begin
        comb_res = '0;
        case (alu_op)
            ALUOP_AND: comb_res = op1 & op2;
            ALUOP_OR:  comb_res = op1 | op2;
            ALUOP_ADD: comb_res = op1 + op2;
            ALUOP_LT:  comb_res = {{(WIDTH-1){1'b0}}, ($signed(op1) < $signed(op2))};
            ALUOP_XOR: comb_res = op1 ^ op2;
            ALUOP_SUB: comb_res = op1 - op2;
            ALUOP_SRL: comb_res = op1 >> shamt;
            ALUOP_SLL: comb_res = op1 << shamt;
            ALUOP_SRA: comb_res = $unsigned($signed(op1) >>> shamt);
            default:   comb_res = '0;
        endcase
    end

`ifdef ALU_SEQ_MUL_EN
    logic             is_mul;
    logic             mul_start;
    logic             mul_done;
    logic [WIDTH-1:0] mul_product;

    assign is_mul    = (alu_op == ALUOP_MUL);
    assign mul_start = accept && is_mul;
    assign busy      = (state == BUSY);

    alu_mul_iter #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) u_mul (
        .clk       (clk),
        .resetn    (resetn),
        .start     (mul_start),
        .mcand_in  (op1),
        .mplier_in (op2),
        .done      (mul_done),
        .product   (mul_product)
    );
`else
    assign busy = 1'b0;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b1;
        end else begin
            case (state)
                // A new accept in DONE implies out_ready, so the old result is
                // consumed on the same edge the new operation is taken.
                IDLE, DONE: begin
                    if (accept) begin
`ifdef ALU_SEQ_MUL_EN
                        if (is_mul) begin
                            state     <= BUSY;
                            out_valid <= 1'b0;
                        end else
`endif
                        begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                            result    <= comb_res;
                            zero      <= (comb_res == '0);
                        end
                    end else if ((state == DONE) && out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
`ifdef ALU_SEQ_MUL_EN
                BUSY: begin
                    if (mul_done) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        result    <= mul_product;
                        zero      <= (mul_product == '0);
                    end
                end
`endif
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed vectors, scoreboard queue, negedge monitor.
// Latency: checked per transaction against the accepting edge where it is deterministic.
// Backpressure: exercises held results, ignored in_valid and simultaneous transfers.
module tb_alu_seq;
    import alu_pkg::*;

    localparam int WIDTH = 32;
    localparam logic [3:0] OP_UNK  = 4'b0111;
    localparam logic [3:0] OP_UNK2 = 4'b1111;

    logic             clk;
    logic             resetn;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] op1;
    logic [WIDTH-1:0] op2;
    logic [3:0]       alu_op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             busy;

    alu_seq #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op1       (op1),
        .op2       (op2),
        .alu_op    (alu_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .busy      (busy)
    );

    typedef struct {
        logic [WIDTH-1:0] res;
        logic             z;
        int               due;
        bit               exact;
        int               id;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   next_id  = 0;
    int   stalls   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: a transfer happens at the next posedge whenever valid&ready here.
    always @(negedge clk) begin
        if (resetn && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_output: got result 0x%0h with no expected entry", result);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check($sformatf("out%0d_result", e.id), result, e.res);
                check($sformatf("out%0d_zero", e.id), zero, e.z);
                if (e.exact) check($sformatf("out%0d_latency", e.id), cyc, e.due);
            end
        end
    end

    // Called just after a posedge; returns just after the accepting posedge.
    task automatic drive(input logic [3:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [WIDTH-1:0] res, input logic z, input int lat, input bit exact);
        exp_t e;
        int   waited;
        alu_op = op; op1 = a; op2 = b; in_valid = 1'b1;
        waited = 0;
        @(negedge clk);
        while (!in_ready && waited < 200) begin
            waited++;
            @(negedge clk);
        end
        if (!in_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL drive_timeout: in_ready stayed 0, expected 1 within 200 cycles");
            in_valid = 1'b0;
            return;
        end
        stalls += waited;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        e.res = res; e.z = z; e.due = cyc + lat; e.exact = exact; e.id = next_id++;
        sb.push_back(e);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("scoreboard_drained", sb.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int bad;
        int n;
        resetn = 1'b0; in_valid = 1'b0; op1 = '0; op2 = '0; alu_op = '0; out_ready = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_result", result, 0);
        check("rst_zero", zero, 1);
        check("rst_busy", busy, 0);
        @(posedge clk); #1 resetn = 1'b1;
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        @(posedge clk); #1;

        // Single-cycle ops, out_ready high
        drive(ALUOP_ADD, 32'd5,        32'd7,        32'd12,       1'b0, 0, 1'b1);
        drive(ALUOP_SUB, 32'h1234,     32'h1234,     32'h0,        1'b1, 0, 1'b1);
        drive(ALUOP_SRA, 32'h80000000, 32'd4,        32'hF8000000, 1'b0, 0, 1'b1);
        drive(ALUOP_LT,  32'hFFFFFFFF, 32'd1,        32'd1,        1'b0, 0, 1'b1);
        drive(ALUOP_LT,  32'd1,        32'hFFFFFFFF, 32'd0,        1'b1, 0, 1'b1);
        drive(ALUOP_LT,  32'h7FFFFFFF, 32'h80000000, 32'd0,        1'b1, 0, 1'b1);
        drive(ALUOP_ADD, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b1, 0, 1'b1);
        drive(ALUOP_SUB, 32'd0,        32'd1,        32'hFFFFFFFF, 1'b0, 0, 1'b1);
        drive(ALUOP_SRL, 32'h80000000, 32'h24,       32'h08000000, 1'b0, 0, 1'b1);
        drive(ALUOP_SLL, 32'd1,        32'd31,       32'h80000000, 1'b0, 0, 1'b1);
        drive(ALUOP_SRA, 32'h7FFFFFF0, 32'd4,        32'h07FFFFFF, 1'b0, 0, 1'b1);
        drive(ALUOP_OR,  32'hF0,       32'h0F,       32'hFF,       1'b0, 0, 1'b1);
        drain();

        // Multiply
`ifdef ALU_SEQ_MUL_EN
        drive(ALUOP_MUL, 32'h0000FFFF, 32'h0000FFFF, 32'hFFFE0001, 1'b0, WIDTH, 1'b1);
        bad = 0; n = 0;
        @(negedge clk);
        while (!out_valid && n < 200) begin
            if (in_ready || !busy) bad++;
            n++;
            @(negedge clk);
        end
        check("mul_in_ready_low_while_busy", bad, 0);
        if (!out_valid) begin
            n_checks++; n_fail++;
            $display("FAIL mul_timeout: out_valid stayed 0, expected 1");
        end
        @(posedge clk); #1;
        drive(ALUOP_MUL, 32'd7,        32'd6,        32'd42, 1'b0, WIDTH, 1'b1);
        drive(ALUOP_MUL, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1,  1'b0, WIDTH, 1'b1);
        drive(ALUOP_MUL, 32'h12345678, 32'd0,        32'd0,  1'b1, WIDTH, 1'b1);
`else
        drive(ALUOP_MUL, 32'h0000FFFF, 32'h0000FFFF, 32'h0, 1'b1, 0, 1'b1);
        check("nomul_busy", busy, 0);
`endif
        drain();

        // Backpressure: ADD 1+1 held, a second op waits
        out_ready = 1'b0;
        drive(ALUOP_ADD, 32'd1, 32'd1, 32'd2, 1'b0, 0, 1'b0);
        alu_op = ALUOP_ADD; op1 = 32'd10; op2 = 32'd20; in_valid = 1'b1;
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (!out_valid || result != 32'd2 || in_ready) bad++;
        end
        check("bp_hold_stable", bad, 0);
        @(posedge clk); #1 out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_in_ready", in_ready, 1);
        @(posedge clk); #1 in_valid = 1'b0;
        begin
            exp_t e;
            e.res = 32'd30; e.z = 1'b0; e.due = cyc; e.exact = 1'b1; e.id = next_id++;
            sb.push_back(e);
        end
        drain();

        // Reset during a multiply (or during a held result without MUL)
        out_ready = 1'b0;
        alu_op = ALUOP_MUL; op1 = 32'd3; op2 = 32'd5; in_valid = 1'b1;
        @(negedge clk);
        check("rstmid_accept_ready", in_ready, 1);
        @(posedge clk); #1 in_valid = 1'b0;
        repeat (9) @(negedge clk);
`ifdef ALU_SEQ_MUL_EN
        check("rstmid_busy_before", busy, 1);
`else
        check("rstmid_valid_before", out_valid, 1);
`endif
        resetn = 1'b0;
        #1;
        check("rstmid_out_valid", out_valid, 0);
        check("rstmid_result", result, 0);
        check("rstmid_zero", zero, 1);
        check("rstmid_busy", busy, 0);
        @(posedge clk); #1 resetn = 1'b1; out_ready = 1'b1;
        repeat (WIDTH + 2) begin
            @(negedge clk);
            if (out_valid) bad++;
        end
        check("rstmid_no_late_valid", out_valid, 0);
        @(posedge clk); #1;
        drive(ALUOP_ADD, 32'd2, 32'd3, 32'd5, 1'b0, 0, 1'b1);

        // Back-to-back single-cycle ops, full throughput
        stalls = 0;
        drive(ALUOP_XOR, 32'hA5A5A5A5, 32'hFFFF0000, 32'h5A5AA5A5, 1'b0, 0, 1'b1);
        drive(ALUOP_AND, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 1'b0, 0, 1'b1);
        drive(OP_UNK,    32'hDEADBEEF, 32'h12345678, 32'h0,        1'b1, 0, 1'b1);
        drive(OP_UNK2,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,        1'b1, 0, 1'b1);
        check("b2b_stalls", stalls, 0);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
